// File: rtl/lcla_seq_sub.sv
// Multi-cycle subtractor: D = A - B - borrow_in, one SLICE-bit slice per clock, LSB slice first.
// Each slice reuses a Ling-style adder as A + ~B + ~borrow; valid/ready handshakes on both sides.
module lcla_seq_sub #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_out,
  output logic             borrow_out,
  output logic             ovf_out,
  output logic             zero_out
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE:0]   slice_res;
  logic             last_slice;

  // Ling factoring: h[i+1] = g[i] | c[i], c[i+1] = t[i] & h[i+1]; returns {carry_out, sum}.
  function automatic logic [SLICE:0] ling_slice_add(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             cin
  );
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] t;
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] s;
    logic [SLICE:0]   c;
    logic             h;
    g    = x & y;
    t    = x | y;
    p    = x ^ y;
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      h      = g[i] | c[i];
      c[i+1] = t[i] & h;
      s[i]   = p[i] ^ c[i];
    end
    return {c[SLICE], s};
  endfunction

  assign a_slice    = a_q[int'(cnt_q)*SLICE +: SLICE];
  assign b_slice    = b_q[int'(cnt_q)*SLICE +: SLICE];
  assign slice_res  = ling_slice_add(a_slice, ~b_slice, ~borrow_q);
  assign last_slice = (cnt_q == CW'(N - 1));

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: a default for every comb output first; without it a missed branch infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a_in;
          b_d      = b_in;
          borrow_d = borrow_in;
          cnt_d    = '0;
        end
      end
      RUN: begin
        d_d[int'(cnt_q)*SLICE +: SLICE] = slice_res[SLICE-1:0];
        borrow_d = ~slice_res[SLICE];
        cnt_d    = CW'(cnt_q + 1'b1);
        if (last_slice) begin
          // The top slice's sum MSB is the result sign; borrow_in plays no part here.
          ovf_d  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (slice_res[SLICE-1] != a_q[WIDTH-1]);
          zero_d = (d_d == '0);
        end
      end
      default: ;
    endcase
  end

  // NOTE: operand/result registers are reset too, because every output must read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  // Results hold their last value after the handshake; flags are registered so reset reads 0.
  always_comb begin
    d_out      = d_q;
    borrow_out = borrow_q;
    ovf_out    = ovf_q;
    zero_out   = zero_q;
  end

endmodule

// File: tb/tb_lcla_seq_sub.sv
// Directed bench for lcla_seq_sub: vector table of hand-computed differences plus
// backpressure and mid-operation reset sequences.
module tb_lcla_seq_sub;

  localparam int WIDTH = 64;
  localparam int SLICE = 16;
  localparam int N     = WIDTH / SLICE;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d_out;
  logic             borrow_out;
  logic             ovf_out;
  logic             zero_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ovf;
    logic             zero;
  } vec_t;

  vec_t vecs[9];

  lcla_seq_sub #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .d_out      (d_out),
    .borrow_out (borrow_out),
    .ovf_out    (ovf_out),
    .zero_out   (zero_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Waits (bounded) for out_valid, sampling 1 time unit after each rising edge.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    a_in      = v.a;
    b_in      = v.b;
    borrow_in = v.bin;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check({v.name, " latency"}, 64'(lat), 64'(N));
    check({v.name, " d"}, d_out, v.d);
    check({v.name, " borrow"}, 64'(borrow_out), 64'(v.bo));
    check({v.name, " ovf"}, 64'(ovf_out), 64'(v.ovf));
    check({v.name, " zero"}, 64'(zero_out), 64'(v.zero));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({v.name, " out_valid drop"}, 64'(out_valid), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    check({tag, " d_out"}, d_out, 64'd0);
    check({tag, " borrow_out"}, 64'(borrow_out), 64'd0);
    check({tag, " ovf_out"}, 64'(ovf_out), 64'd0);
    check({tag, " zero_out"}, 64'(zero_out), 64'd0);
  endtask

  initial begin
    int lat;
    vecs[0] = '{"cross_slice", 64'h0000_0000_0001_0000, 64'h1, 1'b0,
                64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"underflow", 64'h0, 64'h1, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{"signed_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b0,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{"bin_zero", 64'h5, 64'h4, 1'b1,
                64'h0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{"mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                64'h0246_8ACF_1357_9BCF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"max_eq", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                64'h0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{"zero_bin", 64'h0, 64'h0, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{"pos_minus_neg1", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{"ovf_via_bin", 64'h8000_0000_0000_0000, 64'h0, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    borrow_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Backpressure: result held while new operands are offered and ignored.
    a_in      = 64'd100;
    b_in      = 64'd1;
    borrow_in = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp latency", 64'(lat), 64'(N));
    a_in      = 64'h50;
    b_in      = 64'h20;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("bp hold out_valid", 64'(out_valid), 64'd1);
      check("bp hold in_ready", 64'(in_ready), 64'd0);
      check("bp hold d_out", d_out, 64'd99);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp back to idle out_valid", 64'(out_valid), 64'd0);
    check("bp back to idle in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp second accepted", 64'(in_ready), 64'd0);
    wait_valid(lat);
    check("bp second latency", 64'(lat), 64'(N));
    check("bp second d", d_out, 64'h30);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Mid-operation reset after two RUN cycles aborts the operation.
    a_in      = 64'hFFFF_FFFF_FFFF_FFFF;
    b_in      = 64'h1;
    borrow_in = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_vec('{"after_reset", 64'h10, 64'h3, 1'b0, 64'hD, 1'b0, 1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
